// File: rtl/mag_comp_seq_pkg.sv
// Shared definitions for the digit-serial magnitude comparator:
// the 2-bit result encoding and the controller state type.
package mag_comp_pkg;

  typedef logic [1:0] cmp_t;

  localparam cmp_t CMP_EQ = 2'b00;
  localparam cmp_t CMP_GT = 2'b01;
  localparam cmp_t CMP_LT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mag_comp_seq_if.sv
// Start/busy/done handshake bundle for mag_comp_seq; master drives the
// request and operands, slave (the comparator) returns status and result.
interface mag_comp_seq_if
  import mag_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  cmp_t             out;

  modport master (output start, a, b, input busy, done, out);
  modport slave  (input start, a, b, output busy, done, out);

endinterface

// File: rtl/mag_comp_seq_digit_cmp.sv
// Combinational compare of one DIGIT-wide digit pair, result in the
// package comparator encoding.
module digit_cmp
  import mag_comp_pkg::*;
#(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output cmp_t             res_o
);

  always_comb begin
    res_o = CMP_EQ;
    if (a_i > b_i) begin
      res_o = CMP_GT;
    end else if (a_i < b_i) begin
      res_o = CMP_LT;
    end
  end

endmodule

// File: rtl/mag_comp_seq.sv
// Digit-serial WIDTH-bit magnitude comparator, MSB digit first, with early
// exit on the first differing digit. SIGNED_CMP_EN selects two's-complement operands.
module mag_comp_seq
  import mag_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mag_comp_seq_if.slave bus
);

  localparam int unsigned DSAFE = (DIGIT > 0) ? DIGIT : 1;
  localparam int unsigned NDIG  = WIDTH / DSAFE;
  localparam int unsigned CW    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

`ifdef SIGNED_CMP_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] CAP_MASK = WIDTH'(1) << (WIDTH - 1);
`else
  localparam logic [WIDTH-1:0] CAP_MASK = '0;
`endif

  if ((DIGIT < 1) || ((WIDTH % DSAFE) != 0)) begin : g_bad_cfg
    $error("mag_comp_seq: WIDTH must be a nonzero multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  cmp_t             out_q, out_d;
  cmp_t             dres;
  logic             accept;
  logic             decide;

  digit_cmp #(.DIGIT(DSAFE)) u_digit_cmp (
    .a_i   (a_q[WIDTH-1 -: DSAFE]),
    .b_i   (b_q[WIDTH-1 -: DSAFE]),
    .res_o (dres)
  );

  assign accept = bus.start && (state_q != RUN);
  assign decide = (state_q == RUN) && ((dres != CMP_EQ) || (cnt_q == LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      out_q   <= CMP_EQ;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (decide) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result is loaded on the deciding edge so it is valid during the DONE cycle.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    out_d = out_q;
    if (accept) begin
      a_d   = bus.a ^ CAP_MASK;
      b_d   = bus.b ^ CAP_MASK;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      if (decide) begin
        out_d = dres;
      end else begin
        a_d   = a_q << DSAFE;
        b_d   = b_q << DSAFE;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
    bus.out  = out_q;
  end

endmodule

// File: tb/tb_mag_comp_seq.sv
// Directed self-checking bench for mag_comp_seq: an 8-bit/1-bit-digit and a
// 16-bit/4-bit-digit instance sharing clock and reset.
module tb_mag_comp_seq;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  mag_comp_seq_if #(.WIDTH(8))  if8 ();
  mag_comp_seq_if #(.WIDTH(16)) if16 ();

  mag_comp_seq #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  mag_comp_seq #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted start on the 8-bit unit; lat is cycles from the accepting
  // edge to the done cycle, or -1 if done never arrives.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      output int lat, output logic [1:0] res);
    if8.a = a;
    if8.b = b;
    if8.start = 1'b1;
    step();
    if8.start = 1'b0;
    lat = -1;
    res = 2'bxx;
    for (int c = 1; c <= 30; c++) begin
      if (if8.done) begin
        lat = c;
        res = if8.out;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if8.start = 1'b0;  if8.a = '0;  if8.b = '0;
    if16.start = 1'b0; if16.a = '0; if16.b = '0;
    step();
    step();
    total_cnt++; if (if8.busy !== 1'b0) $display("FAIL reset_busy8 got %b want 0", if8.busy); else pass_cnt++;
    total_cnt++; if (if8.done !== 1'b0) $display("FAIL reset_done8 got %b want 0", if8.done); else pass_cnt++;
    total_cnt++; if (if8.out !== 2'b00) $display("FAIL reset_out8 got %b want 00", if8.out); else pass_cnt++;
    total_cnt++; if (if16.busy !== 1'b0) $display("FAIL reset_busy16 got %b want 0", if16.busy); else pass_cnt++;
    total_cnt++; if (if16.done !== 1'b0) $display("FAIL reset_done16 got %b want 0", if16.done); else pass_cnt++;
    total_cnt++; if (if16.out !== 2'b00) $display("FAIL reset_out16 got %b want 00", if16.out); else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_first_digit();
    if8.a = 8'h80;
    if8.b = 8'h7F;
    if8.start = 1'b1;
    step();
    if8.start = 1'b0;
    total_cnt++; if (if8.busy !== 1'b1) $display("FAIL fd_busy_k1 got %b want 1", if8.busy); else pass_cnt++;
    total_cnt++; if (if8.done !== 1'b0) $display("FAIL fd_done_k1 got %b want 0", if8.done); else pass_cnt++;
    step();
    total_cnt++; if (if8.done !== 1'b1) $display("FAIL fd_done_k2 got %b want 1", if8.done); else pass_cnt++;
    total_cnt++; if (if8.busy !== 1'b0) $display("FAIL fd_busy_k2 got %b want 0", if8.busy); else pass_cnt++;
    total_cnt++; if (if8.out !== 2'b01) $display("FAIL fd_out got %b want 01", if8.out); else pass_cnt++;
    step();
    total_cnt++; if (if8.done !== 1'b0) $display("FAIL fd_done_pulse got %b want 0", if8.done); else pass_cnt++;
    total_cnt++; if (if8.busy !== 1'b0) $display("FAIL fd_idle_busy got %b want 0", if8.busy); else pass_cnt++;
    total_cnt++; if (if8.out !== 2'b01) $display("FAIL fd_out_hold got %b want 01", if8.out); else pass_cnt++;
  endtask

  task automatic test_equal();
    int         lat;
    logic [1:0] res;
    // Equal operands run all 8 digits; out must keep the previous 01 until done.
    if8.a = 8'h5A;
    if8.b = 8'h5A;
    if8.start = 1'b1;
    step();
    if8.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      if (c == 8) begin
        total_cnt++; if (if8.out !== 2'b01) $display("FAIL eq_out_hold got %b want 01", if8.out); else pass_cnt++;
      end
      if (if8.done) begin
        lat = c;
        break;
      end
      step();
    end
    total_cnt++; if (lat != 9) $display("FAIL eq_latency got %0d want 9", lat); else pass_cnt++;
    total_cnt++; if (if8.out !== 2'b00) $display("FAIL eq_out got %b want 00", if8.out); else pass_cnt++;
    step();
    run8(8'h5A, 8'h5B, lat, res);
    total_cnt++; if (lat != 9) $display("FAIL lastdig_latency got %0d want 9", lat); else pass_cnt++;
    total_cnt++; if (res !== 2'b10) $display("FAIL lastdig_out got %b want 10", res); else pass_cnt++;
    step();
  endtask

  task automatic test_wide();
    int lat;
    if16.a = 16'h1234;
    if16.b = 16'h1244;
    if16.start = 1'b1;
    step();
    // Start held and operands scrambled while busy must not disturb the run.
    if16.a = 16'hFFFF;
    if16.b = 16'h0000;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      if (if16.done) begin
        lat = c;
        break;
      end
      step();
    end
    if16.start = 1'b0;
    total_cnt++; if (lat != 4) $display("FAIL wide_latency got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (if16.out !== 2'b10) $display("FAIL wide_out got %b want 10", if16.out); else pass_cnt++;
    step();
    total_cnt++; if (if16.busy !== 1'b0) $display("FAIL wide_ignored_start got busy %b want 0", if16.busy); else pass_cnt++;
    total_cnt++; if (if16.done !== 1'b0) $display("FAIL wide_done_pulse got %b want 0", if16.done); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat1 = -1;
    int lat2 = -1;
    int c;
    if8.a = 8'd3;
    if8.b = 8'd9;
    if8.start = 1'b1;
    step();
    c = 1;
    while (c <= 30 && !if8.done) begin
      step();
      c++;
    end
    if (if8.done) lat1 = c;
    total_cnt++; if (lat1 != 6) $display("FAIL b2b_lat1 got %0d want 6", lat1); else pass_cnt++;
    total_cnt++; if (if8.out !== 2'b10) $display("FAIL b2b_out1 got %b want 10", if8.out); else pass_cnt++;
    if8.a = 8'd9;
    if8.b = 8'd3;
    step();
    c++;
    total_cnt++; if (if8.busy !== 1'b1) $display("FAIL b2b_rerun got busy %b want 1", if8.busy); else pass_cnt++;
    while (c <= 40 && !if8.done) begin
      step();
      c++;
    end
    if (if8.done) lat2 = c;
    if8.start = 1'b0;
    total_cnt++; if (lat2 != 12) $display("FAIL b2b_lat2 got %0d want 12", lat2); else pass_cnt++;
    total_cnt++; if (if8.out !== 2'b01) $display("FAIL b2b_out2 got %b want 01", if8.out); else pass_cnt++;
    step();
    total_cnt++; if (if8.busy !== 1'b0) $display("FAIL b2b_idle got busy %b want 0", if8.busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int         lat;
    logic [1:0] res;
    logic       saw_done = 1'b0;
    if8.a = 8'h5A;
    if8.b = 8'h5A;
    if8.start = 1'b1;
    step();
    if8.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++; if (if8.busy !== 1'b0) $display("FAIL rst_run_busy got %b want 0", if8.busy); else pass_cnt++;
    total_cnt++; if (if8.out !== 2'b00) $display("FAIL rst_run_out got %b want 00", if8.out); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      if (if8.done) saw_done = 1'b1;
      step();
    end
    total_cnt++; if (saw_done !== 1'b0) $display("FAIL rst_run_no_done got %b want 0", saw_done); else pass_cnt++;
    run8(8'h80, 8'h7F, lat, res);
    total_cnt++; if (lat != 2) $display("FAIL rst_recover_lat got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (res !== 2'b01) $display("FAIL rst_recover_out got %b want 01", res); else pass_cnt++;
    step();
    // Reset and start together: reset must win.
    rst = 1'b1;
    if8.start = 1'b1;
    step();
    rst = 1'b0;
    if8.start = 1'b0;
    total_cnt++; if (if8.busy !== 1'b0) $display("FAIL rst_start_same got busy %b want 0", if8.busy); else pass_cnt++;
    total_cnt++; if (if8.out !== 2'b00) $display("FAIL rst_start_out got %b want 00", if8.out); else pass_cnt++;
    step();
  endtask

  task automatic test_signed();
    int         lat;
    logic [1:0] res;
    logic [1:0] want;
`ifdef SIGNED_CMP_EN
    want = 2'b10;
`else
    want = 2'b01;
`endif
    run8(8'hFF, 8'h01, lat, res);
    total_cnt++; if (lat != 2) $display("FAIL sign_lat got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (res !== want) $display("FAIL sign_out got %b want %b", res, want); else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_first_digit();
    test_equal();
    test_wide();
    test_back_to_back();
    test_reset_mid_run();
    test_signed();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mag_comp_seq.md
# mag_comp_seq

Parametrised, sequential magnitude comparator. Compares two WIDTH-bit operands digit-serially, MSB digit first, DIGIT bits per cycle, with a start/busy/done handshake and early termination on the first differing digit. Result uses the team's 2-bit comparator encoding (01 greater, 10 less, 00 equal). It replaces the fixed 4-bit combinational comparator in datapaths where operands are wide and area matters more than latency.

## Interface
- WIDTH, 8: operand width in bits; must be a multiple of DIGIT.
- DIGIT, 1: bits compared per cycle; DIGIT = WIDTH gives single-cycle compare.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only when busy = 0.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high while a comparison is running.
- done  output  1  one-cycle pulse when out is updated.
- out  output  2  result: 2'b01 a>b, 2'b10 a<b, 2'b00 a==b; 2'b11 never driven.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0. start=1 → capture a, b into shift registers, digit counter = 0, go RUN.
- RUN: busy=1. Compare top DIGIT bits of both shift registers.
  - A digit > B digit → result 01, go DONE.
  - A digit < B digit → result 10, go DONE.
  - Equal, counter = WIDTH/DIGIT-1 → result 00, go DONE.
  - Equal otherwise → shift both left by DIGIT, counter+1, stay RUN.
- DONE: done=1, out loaded with result, busy=0. start=1 here is accepted (back-to-back), go RUN; else go IDLE.
- start while busy=1 ignored; a/b changes after capture have no effect.
- out holds last result until the next done; never changes outside a done cycle.
- Counter width: clog2(WIDTH/DIGIT), minimum 1 bit.
- Elaboration error if WIDTH % DIGIT ≠ 0 or DIGIT < 1.

## Timing
- Reset: state IDLE, busy=0, done=0, out=2'b00, shift registers and counter 0.
- rst mid-RUN: comparison abandoned, no done pulse, out returns to 00.
- start accepted at edge k → RUN from cycle k+1; digit i examined in cycle k+1+i.
- Decision at digit i → done=1 and out valid in cycle k+2+i.
- Latency from accepting edge to done: min 2 cycles (first digit differs), max WIDTH/DIGIT+1 (equal or last digit differs).
- Back-to-back throughput: one compare per (digits examined + 1) cycles.
- rst and start in same cycle: rst wins.

## Configuration
- SIGNED_CMP_EN defined: operands are two's complement; MSB of a and b inverted at capture, so the unsigned digit-serial compare yields signed ordering (e.g. 8'hFF < 8'h01).
- Undefined: operands unsigned (8'hFF > 8'h01). Latency and handshake identical either way.

## Structure
- Package mag_comp_pkg: result constants CMP_EQ=2'b00, CMP_GT=2'b01, CMP_LT=2'b10; state enum (IDLE, RUN, DONE).
- Sub-module digit_cmp: combinational DIGIT-wide compare of two digits returning a 2-bit result in the package encoding; instantiated once.
- Top holds FSM, shift registers, counter, output register.

## Test plan
- WIDTH=8, DIGIT=1, a=8'h80, b=8'h7F, start at edge k → done in cycle k+2, out=01, busy high only cycle k+1.
- WIDTH=8, DIGIT=1, a=b=8'h5A → done at k+9, out=00; a=8'h5A, b=8'h5B → done at k+9, out=10.
- WIDTH=16, DIGIT=4, a=16'h1234, b=16'h1244 → done at k+4, out=10; start pulses during busy ignored, a/b changed mid-run ignored.
- Back-to-back: start held high, pairs (3,9) then (9,3) → two done pulses, out 10 then 01, second RUN starts the cycle after first done.
- rst asserted in RUN of a 9-cycle compare → busy=0, done never pulses, out=00 next cycle; new start then completes normally.
- SIGNED_CMP_EN, WIDTH=8: a=8'hFF, b=8'h01 → out=10; without macro → out=01.
